// File: rtl/spram_arb_pkg.sv
// Shared types, defaults and the round-robin pointer helper for the
// single-port RAM arbiter and any other shared-macro controllers.
package spram_arb_pkg;

  localparam int MAX_NREQ           = 8;
  localparam int DEFAULT_AWIDTH     = 12;
  localparam int DEFAULT_DWIDTH     = 9;
  localparam int DEFAULT_RD_LATENCY = 1;

  typedef logic [$clog2(MAX_NREQ)-1:0] req_idx_t;
  typedef logic [DEFAULT_AWIDTH-1:0]   addr_t;
  typedef logic [DEFAULT_DWIDTH-1:0]   data_t;

  // Next priority pointer: one past the granted index, or unchanged when idle.
  function automatic req_idx_t rr_next(input req_idx_t ptr, input req_idx_t g,
                                       input logic granted, input int nreq);
    int nxt;
    nxt = (int'(g) + 1) % nreq;
    return granted ? req_idx_t'(nxt) : ptr;
  endfunction

endpackage

// File: rtl/spram_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester at or after ptr
// (wrapping) wins; returns one-hot grant, its index and an any-grant flag.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any_gnt
);

  logic [IW-1:0] cand;

  // Scan from the farthest candidate back to ptr so the closest one wins.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    any_gnt = 1'b0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        idx     = cand;
        any_gnt = 1'b1;
      end
    end
    if (any_gnt) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/spram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port RAM macro between NREQ
// requesters; read data is routed back by a latency-matched tag pipeline.
module spram_rr_arbiter
  import spram_arb_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int AWIDTH     = DEFAULT_AWIDTH,
  parameter int DWIDTH     = DEFAULT_DWIDTH,
  parameter int RD_LATENCY = DEFAULT_RD_LATENCY
) (
  input  logic                   clock0,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*AWIDTH-1:0] addr,
  input  logic [NREQ*DWIDTH-1:0] wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rvalid,
  output logic [DWIDTH-1:0]      rdata,
  output logic                   rce,
  output logic [AWIDTH-1:0]      ra,
  output logic                   wce,
  output logic [AWIDTH-1:0]      wa,
  output logic [DWIDTH-1:0]      wd,
  input  logic [DWIDTH-1:0]      rq
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]     ptr_q;
  logic [NREQ-1:0]   pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;

  logic              sel_we;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_wdata;
  logic              issue_rd;
  logic              issue_wr;

  logic [AWIDTH-1:0] ra_q;
  logic [AWIDTH-1:0] wa_q;

  logic [RD_LATENCY-1:0] vld_q;
  logic [IW-1:0]         tag_q [RD_LATENCY];

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (pick_gnt),
    .idx     (pick_idx),
    .any_gnt (pick_any)
  );

  always_comb begin
    sel_we    = we[pick_idx];
    sel_addr  = addr[int'(pick_idx)*AWIDTH +: AWIDTH];
    sel_wdata = wdata[int'(pick_idx)*DWIDTH +: DWIDTH];
    issue_rd  = !reset && pick_any && !sel_we;
    issue_wr  = !reset && pick_any && sel_we;
  end

  // Idle cycles keep the last issued addresses on the RAM pins.
  always_comb begin
    gnt = reset ? '0 : pick_gnt;
    rce = issue_rd;
    wce = issue_wr;
    ra  = reset ? '0 : (issue_rd ? sel_addr : ra_q);
    wa  = reset ? '0 : (issue_wr ? sel_addr : wa_q);
    wd  = issue_wr ? sel_wdata : '0;
  end

  always_ff @(posedge clock0) begin
    if (reset) begin
      ptr_q <= '0;
      ra_q  <= '0;
      wa_q  <= '0;
      vld_q <= '0;
      for (int k = 0; k < RD_LATENCY; k++) tag_q[k] <= '0;
    end else begin
      ptr_q    <= IW'(rr_next(req_idx_t'(ptr_q), req_idx_t'(pick_idx), pick_any, NREQ));
      if (issue_rd) ra_q <= sel_addr;
      if (issue_wr) wa_q <= sel_addr;
      vld_q[0] <= issue_rd;
      tag_q[0] <= pick_idx;
      for (int k = 1; k < RD_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  // The last tag stage lines up with rq, so the RAM output passes straight through.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (!reset && vld_q[RD_LATENCY-1]) begin
      rvalid[tag_q[RD_LATENCY-1]] = 1'b1;
      rdata                       = rq;
    end
  end

endmodule
